tlu_handshake_receiver: RTL and testbench

- Single-clock, parametrised TLU trigger receiver for EUDET TLU style handshakes.
- Supports four modes: disabled, no handshake, simple handshake, and trigger-data handshake.
- Generates TLU_CLOCK internally by division from CLK, so no separate slow clock domain is needed.
- Delivers each accepted trigger word over a valid/ready interface to the downstream FIFO writer; keeps trigger and abort counters for readout.

---
 rtl/tlu_handshake_receiver.sv | 122 ++++++++++++
 tb/tb_tlu_handshake_receiver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_handshake_receiver.sv
// tlu_handshake_receiver: EUDET-style TLU trigger receiver with internally divided TLU_CLOCK.
// Ports:
//   CLK, RESET                      system clock, asynchronous active-high reset
//   TLU_MODE                        00 off, 01 no handshake, 10 simple, 11 trigger-data
//   DATA_BITS, DATA_MSB_FIRST       word length (0 or too large = DATA_WIDTH) and bit order
//   DATA_DELAY                      sample point in CLK cycles after TLU_CLOCK falls
//   LOW_TIMEOUT                     max cycles waiting for TLU_TRIGGER low (0 = forever)
//   VETO                            downstream near-full, blocks new triggers
//   TLU_TRIGGER / TLU_BUSY / TLU_CLOCK  TLU side handshake lines
//   OUT_VALID / OUT_READY / OUT_DATA    trigger word towards the FIFO writer
//   TRIGGER_ABORT, TRIGGER_COUNT, ABORT_COUNT  abort pulse and readout counters
module tlu_handshake_receiver #(
    parameter int DATA_WIDTH = 31,
    parameter int CLK_DIV    = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [1:0]            TLU_MODE,
    input  logic [5:0]            DATA_BITS,
    input  logic                  DATA_MSB_FIRST,
    input  logic [3:0]            DATA_DELAY,
    input  logic [7:0]            LOW_TIMEOUT,
    input  logic                  VETO,
    input  logic                  TLU_TRIGGER,
    output logic                  TLU_BUSY,
    output logic                  TLU_CLOCK,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  TRIGGER_ABORT,
    output logic [CNT_WIDTH-1:0]  TRIGGER_COUNT,
    output logic [CNT_WIDTH-1:0]  ABORT_COUNT
);
    localparam int DIVW = $clog2(CLK_DIV);
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(CLK_DIV - 1);
    localparam logic [5:0] DW = 6'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, SHIFT, OUTPUT} state_t;

    state_t state, state_n;
    logic trig_prev, trig_edge, msb_l, sample, last, timeout;
    logic [1:0] mode_l, mode_e;
    logic [5:0] n_l, bit_cnt, idx;
    logic [DIVW-1:0] delay_l, div_cnt;
    logic [7:0] low_cnt;

    always_comb begin
        state_n   = state;
        trig_edge = TLU_TRIGGER & ~trig_prev;
        // Settings take effect only once the FSM leaves IDLE
        mode_e    = (state == IDLE) ? TLU_MODE : mode_l;
        sample    = state == SHIFT && !TLU_CLOCK && div_cnt == delay_l;
        last      = sample && bit_cnt == n_l - 6'd1;
        timeout   = LOW_TIMEOUT != 8'd0 && low_cnt + 8'd1 == LOW_TIMEOUT;
        idx       = msb_l ? n_l - 6'd1 - bit_cnt : bit_cnt;
        case (state)
            IDLE:     if (trig_edge && TLU_MODE != 2'b00 && !VETO)
                          state_n = (TLU_MODE == 2'b01) ? OUTPUT : WAIT_LOW;
            WAIT_LOW: if (!TLU_TRIGGER) state_n = (mode_l == 2'b11) ? SHIFT : OUTPUT;
                      else if (timeout) state_n = IDLE;
            SHIFT:    if (last) state_n = OUTPUT;
            default:  if (OUT_READY) state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            trig_prev     <= 1'b0;
            mode_l        <= 2'b00;
            n_l           <= 6'd0;
            msb_l         <= 1'b0;
            delay_l       <= '0;
            low_cnt       <= 8'd0;
            div_cnt       <= '0;
            bit_cnt       <= 6'd0;
            TLU_BUSY      <= 1'b0;
            TLU_CLOCK     <= 1'b0;
            OUT_VALID     <= 1'b0;
            OUT_DATA      <= '0;
            TRIGGER_ABORT <= 1'b0;
            TRIGGER_COUNT <= '0;
            ABORT_COUNT   <= '0;
        end else begin
            state         <= state_n;
            trig_prev     <= TLU_TRIGGER;
            // Mode 01 never asserts BUSY; a veto only does in handshake modes
            TLU_BUSY      <= (state_n != IDLE && mode_e != 2'b01) | (VETO & TLU_MODE[1]);
            TRIGGER_ABORT <= state == WAIT_LOW && TLU_TRIGGER && timeout;
            OUT_VALID     <= state_n == OUTPUT;
            low_cnt       <= (state == WAIT_LOW) ? low_cnt + 8'd1 : 8'd0;
            if (state == IDLE && state_n != IDLE) begin
                mode_l  <= TLU_MODE;
                n_l     <= (DATA_BITS == 6'd0 || DATA_BITS > DW) ? DW : DATA_BITS;
                msb_l   <= DATA_MSB_FIRST;
                delay_l <= (int'(DATA_DELAY) > CLK_DIV - 1) ? DIV_MAX : DIVW'(DATA_DELAY);
            end
            if (state == WAIT_LOW && TLU_TRIGGER && timeout)
                ABORT_COUNT <= ABORT_COUNT + CNT_WIDTH'(1);
            if (OUT_VALID && OUT_READY)
                TRIGGER_COUNT <= TRIGGER_COUNT + CNT_WIDTH'(1);
            if (state != SHIFT && state != OUTPUT && state_n == OUTPUT)
                OUT_DATA <= DATA_WIDTH'(TRIGGER_COUNT);
            if (state != SHIFT && state_n == SHIFT) begin
                TLU_CLOCK <= 1'b1;
                div_cnt   <= '0;
                bit_cnt   <= 6'd0;
                OUT_DATA  <= '0;
            end else if (state == SHIFT) begin
                div_cnt   <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIVW'(1);
                TLU_CLOCK <= last ? 1'b0 : (div_cnt == DIV_MAX) ? ~TLU_CLOCK : TLU_CLOCK;
                if (sample) begin
                    OUT_DATA <= OUT_DATA | (DATA_WIDTH'(TLU_TRIGGER) << idx);
                    bit_cnt  <= bit_cnt + 6'd1;
                end
            end else begin
                TLU_CLOCK <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tlu_handshake_receiver.sv
// tb_tlu_handshake_receiver: scoreboard bench for tlu_handshake_receiver with directed vectors.
module tb_tlu_handshake_receiver;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  TLU_MODE = 2'b00;
    logic [5:0]  DATA_BITS = 6'd0;
    logic        DATA_MSB_FIRST = 1'b0;
    logic [3:0]  DATA_DELAY = 4'd0;
    logic [7:0]  LOW_TIMEOUT = 8'd0;
    logic        VETO = 1'b0;
    logic        TLU_TRIGGER = 1'b0;
    logic        OUT_READY = 1'b0;
    logic        TLU_BUSY, TLU_CLOCK, OUT_VALID, TRIGGER_ABORT;
    logic [30:0] OUT_DATA;
    logic [31:0] TRIGGER_COUNT, ABORT_COUNT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0;
    logic [30:0] exp_q[$];

    tlu_handshake_receiver dut (
        .CLK(CLK), .RESET(RESET), .TLU_MODE(TLU_MODE), .DATA_BITS(DATA_BITS),
        .DATA_MSB_FIRST(DATA_MSB_FIRST), .DATA_DELAY(DATA_DELAY), .LOW_TIMEOUT(LOW_TIMEOUT),
        .VETO(VETO), .TLU_TRIGGER(TLU_TRIGGER), .TLU_BUSY(TLU_BUSY), .TLU_CLOCK(TLU_CLOCK),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .TRIGGER_ABORT(TRIGGER_ABORT), .TRIGGER_COUNT(TRIGGER_COUNT), .ABORT_COUNT(ABORT_COUNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Pops one expected word per accepted transfer; also counts TLU_CLOCK pulses
    task automatic monitor();
        logic prev = 1'b0;
        logic [30:0] e;
        forever begin
            @(negedge CLK);
            if (TLU_CLOCK && !prev) rises++;
            prev = TLU_CLOCK;
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h, want none", OUT_DATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", longint'(OUT_DATA), longint'(e));
                end
            end
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(1);
    endtask

    task automatic wait_lvl(input logic lvl, inout bit ok);
        for (int t = 0; t < 64; t++) begin
            if (TLU_CLOCK == lvl) return;
            tick(1);
        end
        ok = 1'b0;
    endtask

    task automatic wait_valid(inout bit ok);
        for (int t = 0; t < 200; t++) begin
            if (OUT_VALID) return;
            tick(1);
        end
        ok = 1'b0;
    endtask

    // TLU model: presents bit k after the k-th TLU_CLOCK rising edge
    task automatic run11(input logic msb, input logic [30:0] exp);
        bit ok = 1'b1;
        int t0 = 0, tl = 0, r0;
        logic [14:0] w = 15'h1234;
        TLU_MODE = 2'b11; DATA_BITS = 6'd15; DATA_MSB_FIRST = msb; DATA_DELAY = 4'd1;
        LOW_TIMEOUT = 8'd0; OUT_READY = 1'b1;
        exp_q.push_back(exp);
        r0 = rises;
        TLU_TRIGGER = 1'b1;
        tick(2);
        TLU_TRIGGER = 1'b0;
        for (int k = 0; k < 15; k++) begin
            wait_lvl(1'b1, ok);
            if (k == 0) t0 = cyc;
            tl = cyc;
            TLU_TRIGGER = w[k];
            wait_lvl(1'b0, ok);
        end
        wait_valid(ok);
        tick(3);
        chk("shift_handshake_done", ok, 1);
        chk("tlu_clk_pulses", rises - r0, 15);
        chk("tlu_clk_period", tl - t0, 8 * 14);
        chk("busy_after_accept", TLU_BUSY, 0);
        chk("tlu_clk_idle", TLU_CLOCK, 0);
    endtask

    initial begin
        bit ok;
        bit bad;
        int busy_at, ab_at, ab_n;
        fork monitor(); join_none
        tick(2);
        chk("rst_busy", TLU_BUSY, 0);
        chk("rst_clk", TLU_CLOCK, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_abort", TRIGGER_ABORT, 0);
        chk("rst_tcount", TRIGGER_COUNT, 0);
        RESET = 1'b0;
        tick(2);

        run11(1'b0, 31'h1234);
        chk("tcount_lsb", TRIGGER_COUNT, 1);
        // 0x1234 reversed over 15 bits: positions 2,4,5,9,12 -> 12,10,9,5,2
        run11(1'b1, 31'h1624);
        chk("tcount_msb", TRIGGER_COUNT, 2);

        ok = 1'b1;
        TLU_TRIGGER = 1'b1;
        tick(2);
        TLU_TRIGGER = 1'b0;
        wait_lvl(1'b1, ok);
        TLU_TRIGGER = 1'b1;
        wait_lvl(1'b0, ok);
        wait_lvl(1'b1, ok);
        tick(1);
        chk("pre_rst_shift", ok, 1);
        chk("pre_rst_clk", TLU_CLOCK, 1);
        chk("pre_rst_busy", TLU_BUSY, 1);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_clk", TLU_CLOCK, 0);
        chk("async_rst_busy", TLU_BUSY, 0);
        chk("async_rst_valid", OUT_VALID, 0);
        chk("async_rst_tcount", TRIGGER_COUNT, 0);
        chk("async_rst_acount", ABORT_COUNT, 0);
        TLU_TRIGGER = 1'b0;
        tick(2);
        RESET = 1'b0;
        tick(5);
        chk("post_rst_clk", TLU_CLOCK, 0);
        chk("post_rst_busy", TLU_BUSY, 0);

        TLU_MODE = 2'b01;
        OUT_READY = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(31'(i));
            TLU_TRIGGER = 1'b1;
            tick(1);
            TLU_TRIGGER = 1'b0;
            for (int j = 0; j < 9; j++) begin
                if (TLU_BUSY) bad = 1'b1;
                tick(1);
            end
        end
        chk("mode01_busy_seen", bad, 0);
        chk("mode01_tcount", TRIGGER_COUNT, 3);

        do_reset();
        TLU_MODE = 2'b10;
        LOW_TIMEOUT = 8'd5;
        OUT_READY = 1'b1;
        busy_at = -1; ab_at = -1; ab_n = 0;
        TLU_TRIGGER = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (TLU_BUSY && busy_at < 0) busy_at = i;
            if (TRIGGER_ABORT) begin
                ab_n++;
                if (ab_at < 0) ab_at = i;
            end
        end
        TLU_TRIGGER = 1'b0;
        tick(3);
        chk("abort_pulses", ab_n, 1);
        chk("abort_delay", ab_at - busy_at, 5);
        chk("abort_count", ABORT_COUNT, 1);
        chk("abort_tcount", TRIGGER_COUNT, 0);
        chk("abort_busy", TLU_BUSY, 0);

        do_reset();
        TLU_MODE = 2'b10;
        LOW_TIMEOUT = 8'd0;
        OUT_READY = 1'b0;
        ok = 1'b1;
        exp_q.push_back(31'd0);
        TLU_TRIGGER = 1'b1;
        tick(3);
        TLU_TRIGGER = 1'b0;
        wait_valid(ok);
        chk("hold_valid_seen", ok, 1);
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!(OUT_VALID && TLU_BUSY)) bad = 1'b1;
            tick(1);
        end
        chk("hold_valid_busy", bad, 0);
        OUT_READY = 1'b1;
        tick(1);
        chk("accept_valid_drop", OUT_VALID, 0);
        chk("accept_busy_drop", TLU_BUSY, 0);
        VETO = 1'b1;
        tick(2);
        chk("veto_busy", TLU_BUSY, 1);
        TLU_TRIGGER = 1'b1;
        tick(1);
        TLU_TRIGGER = 1'b0;
        tick(10);
        chk("veto_no_valid", OUT_VALID, 0);
        chk("veto_busy_held", TLU_BUSY, 1);
        chk("veto_tcount", TRIGGER_COUNT, 1);
        VETO = 1'b0;
        tick(2);
        chk("unveto_busy", TLU_BUSY, 0);

        tick(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
